// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: ID-stage inputs and staged control outputs of ctrl_pipe_unit.
interface ctrl_pipe_if #(parameter int REG_W = 5, parameter int ALUOP_W = 6, parameter int CNT_W = 16);
    logic               ena;
    logic [5:0]         opcode;
    logic [REG_W-1:0]   rs, rt, rd;
    logic               flush;
    logic               hazard_stall;
    logic               ex_RegDst, ex_ALUSrc, ex_MemRead;
    logic [ALUOP_W-1:0] ex_AluOp;
    logic [REG_W-1:0]   ex_wreg;
    logic               mem_Branch, mem_Jump, mem_MemWrite, mem_MemRead, mem_RegWrite;
    logic [REG_W-1:0]   mem_wreg;
    logic               wb_RegWrite, wb_MemtoReg;
    logic [REG_W-1:0]   wb_wreg;
    logic [CNT_W-1:0]   bubble_cnt;
    modport master (
        output ena, opcode, rs, rt, rd, flush,
        input  hazard_stall, ex_RegDst, ex_ALUSrc, ex_MemRead, ex_AluOp, ex_wreg,
               mem_Branch, mem_Jump, mem_MemWrite, mem_MemRead, mem_RegWrite, mem_wreg,
               wb_RegWrite, wb_MemtoReg, wb_wreg, bubble_cnt
    );
    modport slave (
        input  ena, opcode, rs, rt, rd, flush,
        output hazard_stall, ex_RegDst, ex_ALUSrc, ex_MemRead, ex_AluOp, ex_wreg,
               mem_Branch, mem_Jump, mem_MemWrite, mem_MemRead, mem_RegWrite, mem_wreg,
               wb_RegWrite, wb_MemtoReg, wb_wreg, bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: MIPS control decode staged through ID/EX, EX/MEM, MEM/WB with load-use stall and flush.
module ctrl_pipe_unit #(parameter int REG_W = 5, parameter int ALUOP_W = 6, parameter int CNT_W = 16) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);
    typedef struct packed {
        logic             branch, jump, mem_write, mem_read, reg_write, mem_to_reg;
        logic [REG_W-1:0] wreg;
    } mem_t;
    typedef struct packed {
        logic               reg_dst, alu_src;
        logic [ALUOP_W-1:0] alu_op;
        mem_t               m;
    } bundle_t;
    logic w_load, w_store, w_itype, w_btype, w_rtype, w_jump, w_uses_rt, w_stall;
    bundle_t w_dec, r_ex;
    mem_t r_mem;
    logic r_wb_rw, r_wb_m2r;
    logic [REG_W-1:0] r_wb_wreg;
    logic [CNT_W-1:0] r_cnt;
    assign w_load    = bus.opcode[5:3] == 3'b100;
    assign w_store   = bus.opcode[5:3] == 3'b101;
    assign w_itype   = bus.opcode[5:3] == 3'b001;
    assign w_btype   = bus.opcode[5:1] == 5'b00010;
    assign w_rtype   = bus.opcode == 6'b000000;
    assign w_jump    = bus.opcode == 6'b000010;
    assign w_uses_rt = w_rtype | w_store | w_btype;
    always_comb begin
        w_dec              = '0;
        w_dec.reg_dst      = w_rtype;
        w_dec.alu_src      = w_load | w_store | w_itype;
        w_dec.alu_op       = ALUOP_W'({bus.opcode[3] & ~bus.opcode[5], bus.opcode[2:0],
                                       w_rtype | w_itype, w_btype | w_itype});
        w_dec.m.branch     = w_btype;
        w_dec.m.jump       = w_jump;
        w_dec.m.mem_write  = w_store;
        w_dec.m.mem_read   = w_load;
        w_dec.m.mem_to_reg = w_load;
        w_dec.m.reg_write  = w_load | w_rtype | w_itype;
        w_dec.m.wreg       = w_rtype ? bus.rd : bus.rt;
        // unrecognised opcodes must leave no trace, including AluOp and wreg
        if (!(w_load | w_store | w_itype | w_btype | w_rtype | w_jump)) w_dec = '0;
    end
    assign w_stall = bus.ena & r_ex.m.mem_read & (r_ex.m.wreg != '0) &
                     ((r_ex.m.wreg == bus.rs) | (w_uses_rt & (r_ex.m.wreg == bus.rt)));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb_rw   <= 1'b0;
            r_wb_m2r  <= 1'b0;
            r_wb_wreg <= '0;
            r_cnt     <= '0;
        end else if (bus.ena) begin
            r_ex      <= (w_stall | bus.flush) ? '0 : w_dec;
            r_mem     <= bus.flush ? '0 : r_ex.m;
            r_wb_rw   <= r_mem.reg_write;
            r_wb_m2r  <= r_mem.mem_to_reg;
            r_wb_wreg <= r_mem.wreg;
            if ((w_stall | bus.flush) && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
    assign bus.hazard_stall = w_stall;
    assign bus.ex_RegDst    = r_ex.reg_dst;
    assign bus.ex_ALUSrc    = r_ex.alu_src;
    assign bus.ex_AluOp     = r_ex.alu_op;
    assign bus.ex_MemRead   = r_ex.m.mem_read;
    assign bus.ex_wreg      = r_ex.m.wreg;
    assign bus.mem_Branch   = r_mem.branch;
    assign bus.mem_Jump     = r_mem.jump;
    assign bus.mem_MemWrite = r_mem.mem_write;
    assign bus.mem_MemRead  = r_mem.mem_read;
    assign bus.mem_RegWrite = r_mem.reg_write;
    assign bus.mem_wreg     = r_mem.wreg;
    assign bus.wb_RegWrite  = r_wb_rw;
    assign bus.wb_MemtoReg  = r_wb_m2r;
    assign bus.wb_wreg      = r_wb_wreg;
    assign bus.bubble_cnt   = r_cnt;
endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the single-stage MIPS control decoder.
- Decodes the ID-stage opcode into a control bundle and stages it through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles. Applies branch flushes.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- REG_W, 5, register-index width (rs/rt/rd/write-register).
- ALUOP_W, 6, AluOp width; must be >= 6; bits above 5 are driven 0.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global pipeline advance; 0 freezes all stage registers and the counter.
- opcode  in  6  ID-stage instruction opcode.
- rs  in  REG_W  ID-stage source register 1.
- rt  in  REG_W  ID-stage source register 2 / I-type destination.
- rd  in  REG_W  ID-stage R-type destination.
- flush  in  1  branch taken (resolved in MEM); kill younger instructions.
- hazard_stall  out  1  combinational; load-use stall request to PC/IF-ID.
- ex_RegDst, ex_ALUSrc  out  1 each  EX-stage controls.
- ex_AluOp  out  ALUOP_W  EX-stage ALU operation.
- ex_MemRead  out  1  EX stage holds a load.
- ex_wreg  out  REG_W  EX-stage destination register.
- mem_Branch, mem_Jump, mem_MemWrite, mem_MemRead  out  1 each  MEM-stage controls.
- mem_RegWrite  out  1  MEM-stage write enable (for forwarding).
- mem_wreg  out  REG_W  MEM-stage destination register.
- wb_RegWrite, wb_MemtoReg  out  1 each  WB-stage controls.
- wb_wreg  out  REG_W  WB-stage destination register.
- bubble_cnt  out  CNT_W  number of bubbles inserted; saturating.

Behaviour:
- Reset (rst=0, async): every stage register, every output and bubble_cnt go to 0. Reset mid-operation discards all in-flight bundles.
- Decode (combinational, ID stage):
  - load = opcode[5:3]==100; store = 101; i_type = 001.
  - b_type = opcode[5:1]==00010; r_type = opcode==000000; jump = opcode==000010.
  - Branch = b_type; Jump = jump; MemWrite = store; MemRead = MemtoReg = load.
  - RegDst = r_type; RegWrite = load|r_type|i_type; ALUSrc = load|store|i_type.
  - AluOp[0] = b_type|i_type; AluOp[1] = r_type|i_type; AluOp[4:2] = opcode[2:0]; AluOp[5] = opcode[3]&~opcode[5].
  - wreg = rd if r_type, else rt. Unknown opcodes decode to an all-zero bundle.
- Hazard: uses_rt = r_type|store|b_type. hazard_stall = ena & ex_MemRead & (ex_wreg!=0) & ((ex_wreg==rs) | (uses_rt & ex_wreg==rt)).
- On each rising clk edge with ena=1:
  - ID/EX loads the decoded bundle, or zeros if hazard_stall or flush.
  - EX/MEM loads ID/EX, or zeros if flush.
  - MEM/WB loads EX/MEM unconditionally.
- Flush overrides stall: with both high, ID/EX and EX/MEM are both zeroed. bubble_cnt counts one event per cycle.
- bubble_cnt increments by 1 on each ena=1 cycle where hazard_stall=1 or flush=1. Holds at all-ones; no wrap.
- ena=0: all registers hold; hazard_stall forced 0; flush ignored.
- A zero bundle is a true NOP: no write, no memory access, no branch.
- Latency: decoded controls appear on ex_* 1 cycle after ID, on mem_* after 2, on wb_* after 3.

Test Plan:
- Reset: drive rst=0 mid-stream with ex/mem/wb bundles non-zero -> all outputs and bubble_cnt read 0 immediately, without waiting for a clock edge.
- R-type: opcode=000000, rd=7 -> next cycle ex_RegDst=1, ex_AluOp=6'b000010, ex_wreg=7. Two cycles later wb_RegWrite=1, wb_wreg=7, wb_MemtoReg=0.
- Load-use: lw (opcode=100011, rt=3), then add with rs=3 -> hazard_stall=1 for exactly 1 cycle. A bubble appears in EX, the add reaches EX one cycle late, bubble_cnt=1.
- No false stall: lw to $0, then an instruction using $0 -> hazard_stall=0. Store with rs≠3 and rt=3 behind a lw to $3 -> stall=1.
- Flush with simultaneous stall: assert both -> ID/EX and EX/MEM zeroed the next cycle (mem_MemWrite=0, mem_RegWrite=0), bubble_cnt increments by 1.
- Freeze and saturation: ena=0 for 5 cycles -> outputs unchanged, hazard_stall=0. With CNT_W=2 and 5 stall events -> bubble_cnt ends at 3.
